// File: rtl/streebog_msg_sequencer_pkg.sv
// Shared definitions for the Streebog message sequencer: FSM encoding,
// datapath widths and the last-word masking helper.
package streebog_msg_sequencer_pkg;

    localparam int BLOCK_W = 512;
    localparam int WORD_W  = 32;
    localparam int LEN_W   = 10;
    localparam int CNT_W   = 4;
    localparam int NB_W    = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT,
        S_FILL,
        S_UPDATE,
        S_FINAL,
        S_WAIT_DIG,
        S_DONE
    } state_t;

    // Keeps the top 'bits' bits of the final word; 0 means the whole word is valid.
    function automatic logic [WORD_W-1:0] last_word_mask(input logic [NB_W-1:0] bits);
        if (bits == '0)
            return '1;
        else
            return ~({WORD_W{1'b1}} >> bits);
    endfunction

endpackage

// File: rtl/streebog_msg_sequencer.sv
// Packs 32-bit message words into 512-bit blocks and sequences the
// init/update/final commands of a Streebog hash core.
module streebog_msg_sequencer
    import streebog_msg_sequencer_pkg::*;
#(
    parameter int READY_GUARD = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                short_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_last,
    input  logic [NB_W-1:0]     in_last_bits,
    output logic [BLOCK_W-1:0]  core_block,
    output logic [LEN_W-1:0]    core_block_length,
    output logic                core_init,
    output logic                core_update,
    output logic                core_final,
    output logic                core_short_mode,
    input  logic                core_ready,
    input  logic                core_digest_valid,
    output logic                busy,
    output logic                done
);

    localparam int GW = (READY_GUARD < 1) ? 1 : $clog2(READY_GUARD + 1);

    state_t             state;
    logic [CNT_W-1:0]   word_cnt;
    logic [GW-1:0]      guard;
    logic               final_pending;
    logic               blk_clr;

    logic               accept;
    logic [WORD_W-1:0]  word_masked;
    logic [LEN_W-1:0]   res_bits;
    logic [BLOCK_W-1:0] block_next;

    always_comb begin
        accept      = in_valid && in_ready;
        word_masked = in_last ? (in_data & last_word_mask(in_last_bits)) : in_data;
        res_bits    = {1'b0, word_cnt, 5'b0}
                    + ((in_last_bits == '0) ? 10'd32 : {5'b0, in_last_bits});
        // Block is cleared lazily so the previous block stays on core_block
        // until the first word of the next one arrives.
        block_next  = blk_clr ? '0 : core_block;
        // Slot n occupies bits [511-32n -: 32], i.e. msb index {~n, 5'b11111}.
        block_next[{~word_cnt, 5'b11111} -: WORD_W] = word_masked;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            word_cnt          <= '0;
            guard             <= '0;
            final_pending     <= 1'b0;
            blk_clr           <= 1'b0;
            in_ready          <= 1'b0;
            core_block        <= '0;
            core_block_length <= '0;
            core_init         <= 1'b0;
            core_update       <= 1'b0;
            core_final        <= 1'b0;
            core_short_mode   <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            core_init   <= 1'b0;
            core_update <= 1'b0;
            core_final  <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    core_short_mode   <= short_mode;
                    core_block        <= '0;
                    core_block_length <= '0;
                    word_cnt          <= '0;
                    blk_clr           <= 1'b0;
                    final_pending     <= 1'b0;
                    busy              <= 1'b1;
                    state             <= S_INIT;
                end
                S_INIT: if (core_ready) begin
                    core_init <= 1'b1;
                    guard     <= GW'(READY_GUARD);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (guard != '0) begin
                        guard <= guard - 1'b1;
                    end else if (core_ready) begin
                        if (final_pending) begin
                            core_block        <= '0;
                            core_block_length <= '0;
                            final_pending     <= 1'b0;
                            state             <= S_FINAL;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_FILL;
                        end
                    end
                end
                S_FILL: if (accept) begin
                    core_block <= block_next;
                    blk_clr    <= 1'b0;
                    word_cnt   <= word_cnt + 1'b1;
                    if (in_last && res_bits != 10'd512) begin
                        core_block_length <= res_bits;
                        in_ready          <= 1'b0;
                        state             <= S_FINAL;
                    end else if (word_cnt == 4'd15) begin
                        // A last word that exactly fills the block still needs an empty final.
                        final_pending <= in_last;
                        in_ready      <= 1'b0;
                        state         <= S_UPDATE;
                    end
                end
                S_UPDATE: if (core_ready) begin
                    core_update <= 1'b1;
                    word_cnt    <= '0;
                    blk_clr     <= 1'b1;
                    guard       <= GW'(READY_GUARD);
                    state       <= S_WAIT;
                end
                S_FINAL: if (core_ready) begin
                    core_final <= 1'b1;
                    guard      <= GW'(READY_GUARD);
                    state      <= S_WAIT_DIG;
                end
                S_WAIT_DIG: begin
                    if (guard != '0) begin
                        guard <= guard - 1'b1;
                    end else if (core_digest_valid) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_streebog_msg_sequencer.sv
// Randomized bench: messages are split into 512-bit blocks by a bit-queue model
// and the expected command stream is compared against the core interface.
module tb_streebog_msg_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, short_mode;
    logic         in_valid, in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [4:0]   in_last_bits;
    logic [511:0] core_block;
    logic [9:0]   core_block_length;
    logic         core_init, core_update, core_final, core_short_mode;
    logic         core_ready, core_digest_valid;
    logic         busy, done;

    always #5 clk = ~clk;

    streebog_msg_sequencer #(.READY_GUARD(1)) dut (
        .clk(clk), .rst(rst), .start(start), .short_mode(short_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_last_bits(in_last_bits),
        .core_block(core_block), .core_block_length(core_block_length),
        .core_init(core_init), .core_update(core_update), .core_final(core_final),
        .core_short_mode(core_short_mode), .core_ready(core_ready),
        .core_digest_valid(core_digest_valid), .busy(busy), .done(done)
    );

    typedef struct {
        int           kind;   // 0 init, 1 update, 2 final
        logic [511:0] blk;
        logic [9:0]   len;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [31:0] msg_w[$];
    logic [4:0]  msg_lb;
    logic        cur_sm;
    int          n_cmp = 0, n_bad = 0;
    int          done_cnt = 0;
    bit          hold_after_init = 0;
    bit          abort = 0;
    bit          sender_active = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: concatenate valid message bits, cut into 512-bit blocks.
    task automatic build_expect();
        bit   bq[$];
        cmd_t c;
        int   nb, total, nfull, rem;
        for (int i = 0; i < msg_w.size(); i++) begin
            nb = 32;
            if (i == msg_w.size() - 1 && msg_lb != 0) nb = int'(msg_lb);
            for (int b = 31; b >= 32 - nb; b--) bq.push_back(msg_w[i][b]);
        end
        total = bq.size();
        nfull = total / 512;
        rem   = total % 512;
        exp_q.delete();
        c.kind = 0; c.blk = '0; c.len = '0;
        exp_q.push_back(c);
        for (int k = 0; k < nfull; k++) begin
            c.kind = 1; c.blk = '0; c.len = '0;
            for (int j = 0; j < 512; j++) c.blk[511-j] = bq[k*512+j];
            exp_q.push_back(c);
        end
        c.kind = 2; c.blk = '0; c.len = 10'(rem);
        for (int j = 0; j < rem; j++) c.blk[511-j] = bq[nfull*512+j];
        exp_q.push_back(c);
    endtask

    // Command monitor.
    initial forever begin
        @(negedge clk);
        if (!rst && (core_init || core_update || core_final)) begin
            cmd_t e;
            int   kind;
            kind = core_init ? 0 : (core_update ? 1 : 2);
            chk("one_pulse", $countones({core_init, core_update, core_final}), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", kind, 99);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_kind", kind, e.kind);
                chk("short_mode", core_short_mode, cur_sm);
                if (kind != 0) chk("block", core_block, e.blk);
                if (kind == 2) chk("length", core_block_length, e.len);
            end
        end
        if (!rst && done) done_cnt++;
    end

    // Core model: random ready, optional forced stall after init, digest after final.
    initial begin
        int hold_low = 0;
        int dig_cnt  = -1;
        core_ready = 1'b0;
        core_digest_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                core_ready = 1'b0; core_digest_valid = 1'b0; dig_cnt = -1; hold_low = 0;
            end else begin
                if (core_init && hold_after_init) hold_low = 10;
                if (hold_low > 0) begin
                    chk("hold_in_ready", in_ready, 0);
                    core_ready = 1'b0;
                    hold_low--;
                end else begin
                    core_ready = ($urandom_range(0, 3) != 0);
                end
                if (core_final) dig_cnt = $urandom_range(1, 4);
                if (done) core_digest_valid = 1'b0;
                else if (dig_cnt > 0) dig_cnt--;
                else if (dig_cnt == 0) begin core_digest_valid = 1'b1; dig_cnt = -1; end
            end
        end
    end

    task automatic send_words();
        int t;
        sender_active = 1;
        for (int i = 0; i < msg_w.size() && !abort; i++) begin
            while ($urandom_range(0, 2) == 0 && !abort) begin
                @(negedge clk);
                in_valid = 1'b0;
                start = $urandom_range(0, 1);   // must be ignored while busy
                short_mode = $urandom_range(0, 1);
            end
            @(negedge clk);
            start        = 1'b0;
            in_valid     = 1'b1;
            in_data      = msg_w[i];
            in_last      = (i == msg_w.size() - 1);
            in_last_bits = in_last ? msg_lb : 5'($urandom);
            t = 0;
            while (!in_ready && !abort && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) chk("in_ready_timeout", in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        sender_active = 0;
    endtask

    task automatic fill_random(input int n, input logic [4:0] lb);
        msg_w.delete();
        for (int i = 0; i < n; i++) msg_w.push_back($urandom);
        msg_lb = lb;
    endtask

    task automatic run_msg(input string name, input logic sm);
        int t;
        build_expect();
        done_cnt = 0;
        cur_sm   = sm;
        @(negedge clk);
        start = 1'b1; short_mode = sm;
        @(negedge clk);
        start = 1'b0; short_mode = ~sm;
        send_words();
        t = 0;
        while (done_cnt == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_busy_idle"}, busy, 0);
        chk({name, "_cmds_left"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; short_mode = 1'b0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; in_last_bits = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_block", core_block, 0);
        chk("rst_len", core_block_length, 0);
        chk("rst_pulses", {core_init, core_update, core_final, done}, 0);
        rst = 1'b0;

        msg_w.delete(); msg_w.push_back(32'h61626300); msg_lb = 5'd24;
        run_msg("abc", 1'b0);
        fill_random(16, 5'd0);  run_msg("exact512", 1'b1);
        fill_random(20, 5'd8);  run_msg("w20", 1'b0);
        hold_after_init = 1;
        fill_random(3, 5'd0);   run_msg("stall", 1'b1);
        hold_after_init = 0;
        fill_random(16, 5'd31); run_msg("w16_511", 1'b0);
        fill_random(32, 5'd0);  run_msg("exact1024", 1'b0);
        for (int k = 0; k < 8; k++) begin
            fill_random($urandom_range(1, 40), 5'($urandom));
            run_msg("rand", 1'($urandom));
        end

        // Reset while waiting after an update, then a clean message.
        fill_random(20, 5'd8);
        build_expect();
        cur_sm = 1'b1;
        @(negedge clk);
        start = 1'b1; short_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 0;
        fork send_words(); join_none
        for (int t = 0; t < 2000 && !core_update; t++) @(negedge clk);
        chk("upd_before_rst", core_update, 1);
        rst = 1'b1; abort = 1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_block", core_block, 0);
        chk("mid_rst_len", core_block_length, 0);
        chk("mid_rst_short", core_short_mode, 0);
        chk("mid_rst_pulses", {core_init, core_update, core_final, done}, 0);
        for (int t = 0; t < 100 && sender_active; t++) @(negedge clk);
        rst = 1'b0; abort = 0;
        fill_random(5, 5'd12); run_msg("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
